// File: rtl/logicgate_pkg.sv
// logicgate_pkg: op encodings and the bitwise evaluation helper shared by logicgate_pipe
package logicgate_pkg;

    localparam int OP_W  = 3;
    localparam int MAX_W = 64;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic             zero;
        logic             ones;
        logic             parity;
    } lg_result_t;

    // mask selects the live low bits so inverting ops never leak ones above the width
    function automatic lg_result_t lg_eval(
        input logic [OP_W-1:0]  op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [MAX_W-1:0] mask
    );
        lg_result_t       r;
        logic [MAX_W-1:0] x;
        case (op)
            OP_AND:  x = a & b;
            OP_OR:   x = a | b;
            OP_NAND: x = ~(a & b);
            OP_NOR:  x = ~(a | b);
            OP_XOR:  x = a ^ b;
            OP_XNOR: x = ~(a ^ b);
            OP_NOTA: x = ~a;
            default: x = a;
        endcase
        r.data   = x & mask;
        r.zero   = r.data == '0;
        r.ones   = r.data == mask;
        r.parity = ^r.data;
        return r;
    endfunction

endpackage

// File: rtl/logicgate_stage.sv
// logicgate_stage: one pipeline register holding a result, its flags and a valid bit
module logicgate_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_flags,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_flags
);

    // shift on enable; bubbles only move the valid bit so data and flags keep their last value
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data  <= in_data;
                out_flags <= in_flags;
            end
        end
    end

endmodule

// File: rtl/logicgate_pipe.sv
// logicgate_pipe: pipelined eight-op bitwise unit with accumulator, flags and valid/ready flow control
module logicgate_pipe
    import logicgate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [WIDTH-1:0] acc
);

    localparam logic [MAX_W-1:0] MASK = MAX_W'({WIDTH{1'b1}});

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] res_data;
    lg_result_t       res;
    logic             unused_ok;

    logic             v_in [STAGES];
    logic [WIDTH-1:0] d_in [STAGES];
    logic [2:0]       f_in [STAGES];
    logic             v_q  [STAGES];
    logic [WIDTH-1:0] d_q  [STAGES];
    logic [2:0]       f_q  [STAGES];

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && !rst;
    assign accept    = in_valid && in_ready;
    assign opa       = acc_en ? acc : a;
    assign res       = lg_eval(op, MAX_W'(opa), MAX_W'(b), MASK);
    assign res_data  = res.data[WIDTH-1:0];
    assign unused_ok = &{1'b0, res.data};

    assign out_valid            = v_q[STAGES-1];
    assign c                    = d_q[STAGES-1];
    assign {zero, ones, parity} = f_q[STAGES-1];

    // clear wins over a same-cycle accumulate; the accepted op has already read the old value
    always_ff @(posedge clk)
        if (rst || acc_clr) acc <= '0;
        else if (accept && acc_en) acc <= res_data;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign v_in[s] = accept;
            assign d_in[s] = res_data;
            assign f_in[s] = {res.zero, res.ones, res.parity};
        end else begin : g_link
            assign v_in[s] = v_q[s-1];
            assign d_in[s] = d_q[s-1];
            assign f_in[s] = f_q[s-1];
        end
        logicgate_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (v_in[s]),
            .in_data   (d_in[s]),
            .in_flags  (f_in[s]),
            .out_valid (v_q[s]),
            .out_data  (d_q[s]),
            .out_flags (f_q[s])
        );
    end

endmodule

// File: tb/tb_logicgate_pipe.sv
// tb_logicgate_pipe: directed scenarios plus random traffic against a queue-based reference model
module tb_logicgate_pipe;

    localparam int STAGES = 2;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, acc_en, acc_clr, out_valid, out_ready;
    logic       zero, ones, parity;
    logic [2:0] op;
    logic [7:0] a, b, c, acc;

    typedef struct {
        logic [7:0] d;
        int         pos;
    } item_t;

    item_t      q[$];
    logic [7:0] acc_m  = 8'h00;
    logic [7:0] last_c = 8'h00;
    logic [2:0] last_f = 3'b000;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         rdy_seen = 0;

    logic [7:0] sweep [8] = '{8'h88, 8'hEE, 8'h77, 8'h11, 8'h66, 8'h99, 8'h55, 8'hAA};

    logicgate_pipe #(.WIDTH(8), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .zero      (zero),
        .ones      (ones),
        .parity    (parity),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~(x & y);
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    function automatic logic [2:0] flags_of(input logic [7:0] x);
        return {x == 8'h00, x == 8'hFF, 1'($countones(x) % 2)};
    endfunction

    // one clock: drive, compare against the model before the edge, then advance the model
    task automatic cyc(input logic r, input logic v, input logic [2:0] o, input logic ae,
                       input logic ac, input logic [7:0] av, input logic [7:0] bv, input logic orr);
        logic       ov_m, rdy_m;
        logic [7:0] c_m, res;
        logic [2:0] f_m;
        rst = r; in_valid = v; op = o; acc_en = ae; acc_clr = ac; a = av; b = bv; out_ready = orr;
        #1;
        ov_m  = q.size() > 0 && q[0].pos == STAGES;
        c_m   = ov_m ? q[0].d : last_c;
        f_m   = ov_m ? flags_of(q[0].d) : last_f;
        rdy_m = !r && (!ov_m || orr);
        check("out_valid", out_valid, ov_m);
        check("c", c, c_m);
        check("flags", {zero, ones, parity}, f_m);
        check("acc", acc, acc_m);
        check("in_ready", in_ready, rdy_m);
        if (in_ready && v) rdy_seen++;
        res = ref_op(o, ae ? acc_m : av, bv);
        @(posedge clk);
        if (r) begin
            q.delete();
            acc_m  = 8'h00;
            last_c = 8'h00;
            last_f = 3'b000;
        end else begin
            if (ov_m) begin
                last_c = c_m;
                last_f = f_m;
            end
            if (!ov_m || orr) begin
                if (ov_m) void'(q.pop_front());
                foreach (q[i]) q[i].pos++;
                if (v && rdy_m) q.push_back('{res, 1});
            end
            if (ac) acc_m = 8'h00;
            else if (v && rdy_m && ae) acc_m = res;
        end
        #1;
    endtask

    task automatic idle(input logic orr);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, orr);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; acc_en = 1'b0; acc_clr = 1'b0;
        a = 8'h00; b = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        cyc(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1);
        check("nand_lat_early", out_valid, 1'b0);
        idle(1'b1);
        check("nand_valid", out_valid, 1'b1);
        check("nand_c", c, 8'hCF);
        check("nand_flags", {zero, ones, parity}, 3'b000);
        idle(1'b1);

        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 3'(k), 1'b0, 1'b0, 8'hAA, 8'hCC, 1'b1);
            if (k > 0) check("sweep_c", c, sweep[k-1]);
        end
        idle(1'b1);
        check("sweep_last", c, 8'hAA);
        idle(1'b1);

        cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b1);
        cyc(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'hFF, 8'h02, 1'b1);
        check("acc_c1", c, 8'h01);
        cyc(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'hFF, 8'h04, 1'b1);
        check("acc_c2", c, 8'h03);
        check("acc_val", acc, 8'h07);
        idle(1'b1);
        check("acc_c3", c, 8'h07);
        idle(1'b1);
        idle(1'b1);

        rdy_seen = 0;
        for (int i = 0; i < 6; i++)
            cyc(1'b0, i < 4, 3'($urandom_range(0, 7)), 1'b0, 1'b0,
                8'($urandom), 8'($urandom), 1'b0);
        check("bp_accepted", rdy_seen, 2);
        check("bp_ready_low", in_ready, 1'b0);
        repeat (4) idle(1'b1);

        cyc(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b1);
        cyc(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b1);
        check("xor_c", c, 8'h00);
        check("xor_zero", zero, 1'b1);
        idle(1'b1);
        check("xnor_c", c, 8'hFF);
        check("xnor_ones", ones, 1'b1);
        check("xnor_parity", parity, 1'b0);
        idle(1'b1);

        cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b1);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
        cyc(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h56, 8'h78, 1'b0);
        check("rst_acc_before", acc, 8'h3C);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_acc", acc, 8'h00);
        check("rst_in_ready", in_ready, 1'b0);
        cyc(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1);
        idle(1'b1);
        check("post_rst_valid", out_valid, 1'b1);
        check("post_rst_c", c, 8'h5A);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 49) == 0, 1'($urandom), 3'($urandom_range(0, 7)),
                $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                8'($urandom), 8'($urandom), $urandom_range(0, 9) < 7);
        repeat (STAGES + 2) idle(1'b1);
        check("drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logicgate_pipe.md
# logicgate_pipe

Parametrised, pipelined bitwise logic unit that generalises the team's single-function gate blocks. It offers eight selectable operations, an optional accumulator operand, registered result flags, and a valid/ready handshake with full back-pressure. It sits between a register-file or switch-input stage and any consumer that can stall, such as a display driver or a bus master.

## Interface
Parameters:
- WIDTH, 8: operand and result width in bits (≥1).
- STAGES, 2: pipeline depth in register stages (1..4).

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: upstream presents an operation.
- in_ready, output, 1: unit accepts an operation this cycle.
- op, input, 3: operation select (encoding below).
- acc_en, input, 1: use the accumulator as operand A and write the result back to it.
- acc_clr, input, 1: clear the accumulator (independent of the handshake).
- a, input, WIDTH: operand A, ignored when acc_en=1.
- b, input, WIDTH: operand B.
- out_valid, output, 1: result available.
- out_ready, input, 1: downstream takes the result.
- c, output, WIDTH: result.
- zero, output, 1: c == 0.
- ones, output, 1: c is all ones.
- parity, output, 1: XOR-reduction of c.
- acc, output, WIDTH: current accumulator value.

## Operation
- Op encoding: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A. Operand B is ignored for ops 6 and 7.
- Accept condition: in_valid && in_ready.
- On accept, the result is computed combinationally from (A, b, op) and loaded into stage 1 with its flags and a valid bit.
- Stage k+1 loads from stage k when the pipeline advances.
- Advance/stall rule: advance = !out_valid || out_ready. All stages shift together on advance and hold on stall.
- Ready: in_ready = advance && !rst.
- Bubbles: a cycle with no accept inserts a bubble (valid=0). Bubbles propagate.
- Ordering: results leave in acceptance order, with no loss and no duplication.
- Operand A source: when acc_en=1, operand A is the accumulator.
- Accumulator update: on an accept with acc_en=1, the accumulator is set to the result in the same clock edge. Back-to-back accumulate operations therefore chain without hazard.
- Accumulator priority: acc_clr has priority over an accumulate update in the same cycle. The accepted operation still uses the pre-clear accumulator value as A.
- Flags: zero, ones and parity are computed from the stage-1 result and carried with the data. They are always consistent with c.
- Idle output: c and the flags hold their last value while out_valid=0. They are valid only when out_valid=1.

## Timing
- Reset values: out_valid=0, c=0, zero=0, ones=0, parity=0, acc=0, all stage valid bits 0. in_ready=0 while rst=1 and 1 on the first cycle after rst deasserts.
- Latency: an operation accepted at edge N appears on c/out_valid after edge N+STAGES-1. With STAGES=1, it is visible in the cycle after acceptance.
- Throughput: one operation per cycle when out_ready stays high.
- Stall behaviour: while out_valid=1 and out_ready=0, c, the flags and out_valid hold stable, and in_ready=0.
- Simultaneous accept and output: allowed in the same cycle when out_ready=1.
- Reset mid-operation: every in-flight result is discarded, acc returns to 0, and out_valid=0 on the next cycle.
- Width: no arithmetic and no carries. All operations are bitwise at WIDTH bits.

## Structure
- Package logicgate_pkg holds:
  - op localparams OP_AND..OP_PASS;
  - the op width constant (3);
  - a function computing (result, zero, ones, parity) from op, A and B.
- Sub-module logicgate_stage is one pipeline register stage holding valid, WIDTH data and 3 flags, with en and rst. It is instantiated STAGES times in a generate loop.
- The top level contains the operand mux, the accumulator and the handshake logic.

## Test plan
All scenarios use WIDTH=8, STAGES=2.
- Basic op: op=2 (NAND), a=F0, b=3C -> c=CF, zero=0, ones=0, parity=0. out_valid rises after the second edge following accept.
- Op sweep: a=AA, b=CC on 8 consecutive cycles with ops 0..7 -> results 88, EE, 77, 11, 66, 99, 55, AA in order, one per cycle.
- Accumulate: pulse acc_clr, then op=1 (OR) with acc_en=1 and b=01, 02, 04 back to back -> c=01, 03, 07, and acc=07 afterwards.
- Back-pressure: out_ready=0 for 6 cycles while 4 operations are offered -> only 2 accepted, in_ready=0, c held stable. On release, all results emerge in order with no duplicates.
- Flags: XOR with a=b=5A -> c=00, zero=1. XNOR with a=b=5A -> c=FF, ones=1, parity=0.
- Reset mid-flight: assert rst with 2 results in flight and acc=3C -> next cycle out_valid=0, acc=00, in_ready=0. After release, a new operation completes normally.
